my_shift_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register.
- Provides hold, serial shift right, serial shift left and parallel load.
- Adds a clock enable, a synchronous clear, and a saturating shift counter with a full flag.
- Used as the general storage and serialiser primitive for later exercises (SIPO/PISO conversion, delay lines).

---
 rtl/my_shift_reg_if.sv | 28 ++
 rtl/my_shift_reg.sv | 90 +++++++++
 tb/tb_my_shift_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/my_shift_reg_if.sv
// Control and data bundle for my_shift_reg. The master drives commands and parallel data.
// The slave (the register) returns its contents, its serial outputs and the shift count.
interface my_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clr;
    logic             en;
    logic [1:0]       mode;
    logic             si;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic [CNT_W-1:0] cnt;
    logic             full;

    modport master (
        output clr, en, mode, si, d,
        input  q, so_r, so_l, cnt, full
    );

    modport slave (
        input  clr, en, mode, si, d,
        output q, so_r, so_l, cnt, full
    );
endinterface

// File: rtl/my_shift_reg.sv
// WIDTH-bit universal register: hold, shift right, shift left and parallel load.
// Also provides a clock enable, a synchronous clear and a saturating shift counter with a full flag.
module my_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    my_shift_reg_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);
    localparam logic [1:0]       MODE_HOLD = 2'b00;
    localparam logic [1:0]       MODE_SHR  = 2'b01;
    localparam logic [1:0]       MODE_SHL  = 2'b10;
    localparam logic [1:0]       MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shr_w;
    logic [WIDTH-1:0] shl_w;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             full_q;
    logic             full_d;
    logic             shift_w;
    logic             load_w;

    assign shift_w = bus.en && ((bus.mode == MODE_SHR) || (bus.mode == MODE_SHL));
    assign load_w  = bus.en && (bus.mode == MODE_LOAD);
    assign shr_w   = {bus.si, q_q[WIDTH-1:1]};
    assign shl_w   = {q_q[WIDTH-2:0], bus.si};

    // Per-bit next-state mux. si and d are only selected when en=1 and
    // a shift or load is requested, so unknowns on them cannot leak in otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_next;

            always_comb begin
                bit_next = q_q[gi];
                if (bus.clr) begin
                    bit_next = RESET_VALUE[gi];
                end else if (bus.en) begin
                    case (bus.mode)
                        MODE_HOLD: bit_next = q_q[gi];
                        MODE_SHR:  bit_next = shr_w[gi];
                        MODE_SHL:  bit_next = shl_w[gi];
                        MODE_LOAD: bit_next = bus.d[gi];
                        default:   bit_next = q_q[gi];
                    endcase
                end
            end

            assign q_d[gi] = bit_next;
        end
    endgenerate

    // The counter counts shift operations regardless of direction and sticks at WIDTH.
    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        if (bus.clr || load_w) begin
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (shift_w && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            full_d = (cnt_q == (CNT_MAX - 1'b1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RESET_VALUE;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.so_r = q_q[0];
    assign bus.so_l = q_q[WIDTH-1];
    assign bus.cnt  = cnt_q;
    assign bus.full = full_q;
endmodule

// File: tb/tb_my_shift_reg.sv
// Bench for my_shift_reg (WIDTH=8): directed reset sequence, a vector table of the
// documented scenarios, then random traffic against an arithmetic reference model.
module tb_my_shift_reg;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h00;

    typedef struct {
        logic       clr;
        logic       en;
        logic [1:0] mode;
        logic       si;
        logic [7:0] d;
        logic [7:0] eq;
        int         ec;
        logic       ef;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    logic [7:0] mq;
    int         mc;

    my_shift_reg_if #(.WIDTH(W)) bus ();

    my_shift_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input int ec, input logic ef);
        check({tag, " q"},    32'(bus.q),    32'(eq));
        check({tag, " cnt"},  32'(bus.cnt),  32'(ec));
        check({tag, " full"}, 32'(bus.full), 32'(ef));
        check({tag, " so_r"}, 32'(bus.so_r), 32'(eq[0]));
        check({tag, " so_l"}, 32'(bus.so_l), 32'(eq[W-1]));
    endtask

    task automatic drive(input logic c, input logic e, input logic [1:0] m,
                         input logic s, input logic [7:0] dd);
        bus.clr  = c;
        bus.en   = e;
        bus.mode = m;
        bus.si   = s;
        bus.d    = dd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic e, input logic [1:0] m, input logic s,
                                input logic [7:0] dd, input logic [7:0] eq, input int ec, input logic ef);
        vec_t v;
        v.clr = c; v.en = e; v.mode = m; v.si = s; v.d = dd;
        v.eq = eq; v.ec = ec; v.ef = ef;
        return v;
    endfunction

    // Reference: treat q as a number; shifts are divide/multiply by two with si entering at the open end.
    task automatic model_edge(input logic c, input logic e, input logic [1:0] m,
                              input logic s, input logic [7:0] dd);
        if (c) begin
            mq = RV;
            mc = 0;
        end else if (e) begin
            if (m == 2'd1 || m == 2'd2) begin
                if (m == 2'd1) mq = 8'((int'(mq) / 2) + (s ? 128 : 0));
                else           mq = 8'((int'(mq) * 2) % 256 + (s ? 1 : 0));
                if (mc < W) mc++;
            end else if (m == 2'd3) begin
                mq = dd;
                mc = 0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);

        // Async reset, load through release, then a mid-cycle reset
        step();
        check_all("reset", 8'h00, 0, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 8'hFF);
        rst = 1'b0;
        step();
        check("load_ff q", 32'(bus.q), 32'h0000_00FF);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
        step();
        check("shr0 q", 32'(bus.q), 32'h0000_007F);
        check("shr0 cnt", 32'(bus.cnt), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_all("midrst", 8'h00, 0, 1'b0);
        #1 rst = 1'b0;
        $display("directed reset sequence done");

        // Vector table: load, right shift to saturation, left shift, enable, clear, reload
        vecs.push_back(mk(0, 1, 2'b11, 0, 8'hA5, 8'hA5, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hD2, 1, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hE9, 2, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hF4, 3, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hFA, 4, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hFD, 5, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hFE, 6, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hFF, 7, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hFF, 8, 1));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h00, 8'hFF, 8, 1));
        vecs.push_back(mk(0, 1, 2'b11, 0, 8'hA5, 8'hA5, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h00, 8'h4A, 1, 0));
        vecs.push_back(mk(0, 0, 2'b11, 0, 8'h3C, 8'h4A, 1, 0));
        vecs.push_back(mk(0, 0, 2'b11, 0, 8'h3C, 8'h4A, 1, 0));
        vecs.push_back(mk(0, 0, 2'b11, 1'bx, 8'hxx, 8'h4A, 1, 0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h03, 2, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 8'h00, 8'h01, 3, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h03, 4, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h07, 5, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h0F, 6, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h1F, 7, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 8'h00, 8'h3F, 8, 1));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h00, 8'h7E, 8, 1));
        vecs.push_back(mk(0, 1, 2'b11, 0, 8'h0F, 8'h0F, 0, 0));
        vecs.push_back(mk(0, 1, 2'b00, 1'bx, 8'hxx, 8'h0F, 0, 0));
        vecs.push_back(mk(0, 1, 2'b00, 1, 8'hAA, 8'h0F, 0, 0));
        vecs.push_back(mk(1, 1, 2'b11, 1, 8'h55, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].si, vecs[i].d);
            step();
            $display("vec %0d clr=%b en=%b mode=%b si=%b d=%h -> q=%h cnt=%0d full=%b",
                     i, vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].si, vecs[i].d,
                     bus.q, bus.cnt, bus.full);
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ec, vecs[i].ef);
        end

        // Random traffic against the reference model, with occasional mid-cycle resets
        mq = RV;
        mc = 0;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        step();
        check_all("rnd_init", mq, mc, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic       c, e, s;
            logic [1:0] m;
            logic [7:0] dd;
            int         r;
            r  = int'($urandom_range(0, 9));
            c  = ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 7) != 0);
            m  = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10);
            s  = 1'($urandom_range(0, 1));
            dd = 8'($urandom);
            drive(c, e, m, s, dd);
            step();
            model_edge(c, e, m, s, dd);
            $display("rnd %0d clr=%b en=%b mode=%b si=%b d=%h -> q=%h cnt=%0d full=%b",
                     i, c, e, m, s, dd, bus.q, bus.cnt, bus.full);
            check_all($sformatf("rnd%0d", i), mq, mc, mc == W);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                #1;
                mq = RV;
                mc = 0;
                check_all($sformatf("rnd%0d_rst", i), mq, mc, 1'b0);
                #1 rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
